// File: rtl/key_msg_gen_if.sv
// Key-event / ASCII byte-stream bundle for key_msg_gen.
// The slave side is the message generator; the master side is its environment.
interface key_msg_gen_if #(
    parameter int KEY_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
);
    logic                        key_flag;
    logic [KEY_WIDTH-1:0]        key_value;
    logic                        tx_ready;
    logic                        ovf_clr;
    logic                        tx_valid;
    logic [7:0]                  tx_data;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        overflow;

    modport master (
        output key_flag, key_value, tx_ready, ovf_clr,
        input  tx_valid, tx_data, busy, fifo_level, overflow
    );

    modport slave (
        input  key_flag, key_value, tx_ready, ovf_clr,
        output tx_valid, tx_data, busy, fifo_level, overflow
    );
endinterface

// File: rtl/key_msg_gen.sv
// Queues key events and sends each as ASCII "K<hex>\r\n" over a valid/ready byte stream.
// Define KEY_MSG_SEQ_EN to insert "#<seq>" after the key digit (rolling 4-bit message count).
module key_msg_gen #(
    parameter int KEY_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    key_msg_gen_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
`ifdef KEY_MSG_SEQ_EN
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic [2:0] LAST = 3'd3;
`endif

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [0:0]    state;
    logic [2:0]    idx;
    logic [3:0]    msg_key;
    logic          overflow;
    logic [7:0]    msg_byte;
    logic [3:0]    key_ext;
    logic          push;
    logic          pop;
    logic          drop;
    logic          xfer;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? {4'h3, v} : (8'h37 + {4'h0, v});
    endfunction

    assign key_ext = 4'(bus.key_value);

    // A full FIFO still accepts a key when the idle FSM pops in the same cycle.
    assign pop  = (state == IDLE) && (level != '0);
    assign push = bus.key_flag && ((level < DEPTH_L) || pop);
    assign drop = bus.key_flag && !push;
    assign xfer = (state == SEND) && bus.tx_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            msg_key <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        msg_key <= mem[rd_ptr];
                        idx     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx == LAST) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_MSG_SEQ_EN
    logic [3:0] seq;
    logic [3:0] msg_seq;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq     <= '0;
            msg_seq <= '0;
        end else begin
            if (xfer && (idx == LAST)) begin
                seq <= seq + 1'b1;
            end
            if (pop) begin
                msg_seq <= seq;
            end
        end
    end
`endif

    always_comb begin
        msg_byte = 8'h00;
        case (idx)
            3'd0: msg_byte = 8'h4B;
            3'd1: msg_byte = hex_ascii(msg_key);
`ifdef KEY_MSG_SEQ_EN
            3'd2: msg_byte = 8'h23;
            3'd3: msg_byte = hex_ascii(msg_seq);
            3'd4: msg_byte = 8'h0D;
            3'd5: msg_byte = 8'h0A;
`else
            3'd2: msg_byte = 8'h0D;
            3'd3: msg_byte = 8'h0A;
`endif
            default: msg_byte = 8'h00;
        endcase
    end

    assign bus.tx_valid   = (state == SEND);
    assign bus.busy       = (state == SEND);
    assign bus.tx_data    = (state == SEND) ? msg_byte : 8'h00;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_key_msg_gen.sv
// Bench for key_msg_gen: queue-based message model checked every cycle, directed
// scenarios with literal byte expectations, then a randomized soak.
module tb_key_msg_gen;
    localparam int KW    = 4;
    localparam int DEPTH = 4;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_msg_gen_if #(.KEY_WIDTH(KW), .FIFO_DEPTH(DEPTH)) bus ();

    key_msg_gen #(.KEY_WIDTH(KW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    int  pend[$];
    bq_t cur;
    bit  m_ovf;
    int  m_seq;
    int  mdl_lvl;
    bit  mdl_pop;
    bit  mdl_drop;

    bq_t got;
    bq_t exp_q;
    int  lit_seq;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic byte unsigned hexa(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    function automatic bq_t build_msg(input int k);
        bq_t q;
        q.push_back(8'h4B);
        q.push_back(hexa(k));
`ifdef KEY_MSG_SEQ_EN
        q.push_back(8'h23);
        q.push_back(hexa(m_seq));
`endif
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    // Reference: pending keys in a queue, the message in flight as a byte queue.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            cur.delete();
            m_ovf = 1'b0;
            m_seq = 0;
        end else begin
            mdl_lvl  = pend.size();
            mdl_pop  = (cur.size() == 0) && (mdl_lvl > 0);
            mdl_drop = bus.key_flag && !((mdl_lvl < DEPTH) || mdl_pop);
            if (cur.size() != 0 && bus.tx_ready) begin
                void'(cur.pop_front());
                if (cur.size() == 0) m_seq = (m_seq + 1) % 16;
            end
            if (mdl_pop) cur = build_msg(pend.pop_front());
            if (bus.key_flag && !mdl_drop) pend.push_back(int'(bus.key_value));
            if (mdl_drop) m_ovf = 1'b1;
            else if (bus.ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_valid", int'(bus.tx_valid), (cur.size() != 0) ? 1 : 0);
            check("busy", int'(bus.busy), (cur.size() != 0) ? 1 : 0);
            check("tx_data", int'(bus.tx_data), (cur.size() != 0) ? int'(cur[0]) : 0);
            check("fifo_level", int'(bus.fifo_level), pend.size());
            check("overflow", int'(bus.overflow), int'(m_ovf));
            if (prev_stall)
                check("stall_hold", int'({bus.tx_valid, bus.tx_data}), int'({1'b1, prev_data}));
            prev_stall = bus.tx_valid && !bus.tx_ready && !rst;
            prev_data  = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready && !rst) got.push_back(bus.tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_key(input int k);
        bus.key_flag  = 1'b1;
        bus.key_value = KW'(k);
        tick();
        bus.key_flag  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        lit_seq = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.busy || bus.fifo_level != 0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", (n < budget) ? 1 : 0, 1);
    endtask

    task automatic add_lit(input byte unsigned k);
        exp_q.push_back(8'h4B);
        exp_q.push_back(k);
`ifdef KEY_MSG_SEQ_EN
        exp_q.push_back(8'h23);
        exp_q.push_back(hexa(lit_seq));
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        lit_seq = (lit_seq + 1) % 16;
    endtask

    task automatic expect_got(input string name);
        check({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check({name, "_byte"}, int'(got[i]), int'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.key_flag  = 1'b0;
        bus.key_value = '0;
        bus.tx_ready  = 1'b0;
        bus.ovf_clr   = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        do_reset();

        check("rst_tx_valid", int'(bus.tx_valid), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_level", int'(bus.fifo_level), 0);
        check("rst_overflow", int'(bus.overflow), 0);

        // Single event: push at edge N, pop at N+1, tx_valid from cycle N+2.
        bus.tx_ready = 1'b1;
        pulse_key(3);
        check("t1_n1_valid", int'(bus.tx_valid), 0);
        check("t1_n1_level", int'(bus.fifo_level), 1);
        tick();
        check("t1_n2_valid", int'(bus.tx_valid), 1);
        check("t1_n2_data", int'(bus.tx_data), 8'h4B);
        check("t1_n2_level", int'(bus.fifo_level), 0);
        wait_idle(50);
        add_lit(8'h33);
        expect_got("t1");
        check("t1_busy_end", int'(bus.busy), 0);

        // Backpressure: ready pattern 1-0-0.
        pulse_key(4'hA);
        for (int i = 0; i < 30; i++) begin
            bus.tx_ready = (i % 3 == 0);
            tick();
        end
        bus.tx_ready = 1'b1;
        wait_idle(50);
        add_lit(8'h41);
        expect_got("t2");

        // Queueing: the first event is popped straight away, the other two wait.
        do_reset();
        bus.tx_ready = 1'b0;
        pulse_key(1);
        pulse_key(2);
        pulse_key(3);
        tick();
        check("t3_level", int'(bus.fifo_level), 2);
        check("t3_busy", int'(bus.busy), 1);
        check("t3_data", int'(bus.tx_data), 8'h4B);
        bus.tx_ready = 1'b1;
        wait_idle(100);
        add_lit(8'h31);
        add_lit(8'h32);
        add_lit(8'h33);
        expect_got("t3");

        // Overflow: one message in flight plus DEPTH queued, then drops.
        do_reset();
        bus.tx_ready = 1'b0;
        for (int k = 5; k <= 9; k++) pulse_key(k);
        check("t4_level_full", int'(bus.fifo_level), DEPTH);
        check("t4_ovf_before", int'(bus.overflow), 0);
        pulse_key(4'hC);
        check("t4_level_drop", int'(bus.fifo_level), DEPTH);
        check("t4_ovf_set", int'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        pulse_key(4'hD);
        check("t4_ovf_set_wins", int'(bus.overflow), 1);
        tick();
        bus.ovf_clr = 1'b0;
        check("t4_ovf_cleared", int'(bus.overflow), 0);
        bus.tx_ready = 1'b1;
        wait_idle(100);
        for (int k = 5; k <= 9; k++) add_lit(hexa(k));
        expect_got("t4");

        // Reset after byte 1 accepted, with a second key queued behind it.
        do_reset();
        bus.tx_ready = 1'b1;
        pulse_key(7);
        tick();
        pulse_key(9);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", int'(bus.tx_valid), 0);
        check("t5_level", int'(bus.fifo_level), 0);
        check("t5_partial_count", got.size(), 2);
        got.delete();
        lit_seq = 0;
        pulse_key(8);
        wait_idle(50);
        add_lit(8'h38);
        expect_got("t5");

`ifdef KEY_MSG_SEQ_EN
        do_reset();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pulse_key((i * 7) % 16);
            wait_idle(40);
            add_lit(hexa((i * 7) % 16));
        end
        check("t6_first_seq", int'(got[3]), 8'h30);
        check("t6_wrap_seq", int'(got[16 * 6 + 3]), 8'h30);
        expect_got("t6");
`endif

        // Randomized soak with phases of heavy backpressure.
        do_reset();
        for (int p = 0; p < 30; p++) begin
            int rdy_pct = (p % 3 == 0) ? 10 : ((p % 3 == 1) ? 60 : 95);
            for (int i = 0; i < 100; i++) begin
                bus.key_flag  = ($urandom % 4 == 0);
                bus.key_value = KW'($urandom);
                bus.tx_ready  = ($urandom % 100) < rdy_pct;
                bus.ovf_clr   = ($urandom % 20 == 0);
                rst           = ($urandom % 700 == 0);
                tick();
            end
        end
        bus.key_flag = 1'b0;
        bus.ovf_clr  = 1'b0;
        rst          = 1'b0;
        bus.tx_ready = 1'b1;
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
